// File: rtl/adder_result_checker_pkg.sv
// rtl/adder_result_checker_pkg.sv - shared FSM encoding and default sizes for the adder checker
package adder_result_checker_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_VEC = 512;

endpackage

// File: rtl/adder_result_checker_sat_counter.sv
// rtl/adder_result_checker_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - two-stage checker comparing an adder's {co,s} against x+y+ci
module adder_result_checker
    import adder_result_checker_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_on_err,
    input  logic             vld,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic [WIDTH-1:0] s,
    input  logic             co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_x,
    output logic [WIDTH-1:0] fail_y,
    output logic             fail_ci,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_co
);

    localparam int VW = $clog2(NUM_VEC + 1);

    logic [1:0]       state_q, state_d;
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d, s1_s_q, s1_s_d;
    logic             s1_ci_q, s1_ci_d, s1_co_q, s1_co_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic [WIDTH-1:0] fx_q, fx_d, fy_q, fy_d, fs_q, fs_d;
    logic             fci_q, fci_d, fco_q, fco_d;

    logic [WIDTH:0]   golden;
    logic             cmp, match, last, clr;

    // Samples captured outside CHECK never enter the pipeline, so stray vld is harmless.
    always_comb begin
        s1_vld_d = vld && (state_q == CHECK);
        s1_x_d   = x;
        s1_y_d   = y;
        s1_ci_d  = ci;
        s1_s_d   = s;
        s1_co_d  = co;
    end

    assign golden = {1'b0, s1_x_q} + {1'b0, s1_y_q} + {{WIDTH{1'b0}}, s1_ci_q};
    assign cmp    = s1_vld_q && (state_q == CHECK);
    assign match  = ({s1_co_q, s1_s_q} == golden);
    assign last   = cmp && (vec_q == VW'(NUM_VEC - 1));

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CHECK;
                    clr     = 1'b1;
                end
            end
            CHECK: begin
                if (last || (cmp && !match && stop_on_err)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d = vec_q;
        fx_d  = fx_q;
        fy_d  = fy_q;
        fci_d = fci_q;
        fs_d  = fs_q;
        fco_d = fco_q;
        if (clr) begin
            vec_d = '0;
            fx_d  = '0;
            fy_d  = '0;
            fci_d = 1'b0;
            fs_d  = '0;
            fco_d = 1'b0;
        end else if (cmp) begin
            vec_d = vec_q + 1'b1;
            // An error count of zero marks the first mismatch of this run.
            if (!match && (err_cnt == '0)) begin
                fx_d  = s1_x_q;
                fy_d  = s1_y_q;
                fci_d = s1_ci_q;
                fs_d  = s1_s_q;
                fco_d = s1_co_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_vld_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_ci_q  <= 1'b0;
            s1_s_q   <= '0;
            s1_co_q  <= 1'b0;
            vec_q    <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            fci_q    <= 1'b0;
            fs_q     <= '0;
            fco_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= s1_vld_d;
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_ci_q  <= s1_ci_d;
            s1_s_q   <= s1_s_d;
            s1_co_q  <= s1_co_d;
            vec_q    <= vec_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            fci_q    <= fci_d;
            fs_q     <= fs_d;
            fco_q    <= fco_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (cmp && match),
        .cnt   (pass_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (cmp && !match),
        .cnt   (err_cnt)
    );

    assign busy    = (state_q == CHECK);
    assign done    = (state_q == DONE);
    assign pass    = done && (err_cnt == '0);
    assign fail_x  = fx_q;
    assign fail_y  = fy_q;
    assign fail_ci = fci_q;
    assign fail_s  = fs_q;
    assign fail_co = fco_q;

endmodule
